// File: rtl/sr_flag_pkg.sv
// Shared mode constants and the set/clear contention resolver for the flag bank.
package sr_flag_pkg;

    localparam int unsigned MODE_RST_DOM = 0;
    localparam int unsigned MODE_SET_DOM = 1;
    localparam int unsigned MODE_TOGGLE  = 2;
    localparam int unsigned MODE_HOLD    = 3;

    // Next flag value for one channel from its set/clear requests and the current value.
    function automatic logic resolve_q(input logic set_i, input logic clr_i,
                                       input logic q_i, input int unsigned mode);
        logic nq;
        nq = q_i;
        if (set_i && !clr_i) begin
            nq = 1'b1;
        end else if (!set_i && clr_i) begin
            nq = 1'b0;
        end else if (set_i && clr_i) begin
            case (mode)
                MODE_RST_DOM: nq = 1'b0;
                MODE_SET_DOM: nq = 1'b1;
                MODE_TOGGLE:  nq = ~q_i;
                default:      nq = q_i;
            endcase
        end
        return nq;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One set/reset flag channel with optional auto-clear timeout.
// Edge pulse outputs exist only when SR_FLAG_BANK_EDGE_OUT_EN is defined.
module sr_flag_cell
    import sr_flag_pkg::*;
#(
    parameter int unsigned MODE    = 0,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ce_i,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o,
    output logic q_n_o,
    output logic expired_o
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam logic [CNT_W-1:0] RELOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic             q_q, q_d;
    logic             qn_q;
    logic             exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Explicit requests take priority; the timeout only steps when neither is present.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        exp_d = 1'b0;
        if (ce_i) begin
            q_d = resolve_q(set_i, clr_i, q_q, MODE);
            if (set_i || clr_i) begin
                cnt_d = q_d ? RELOAD : '0;
            end else if ((TIMEOUT != 0) && q_q) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    q_d   = 1'b0;
                    exp_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q   <= 1'b0;
            qn_q  <= 1'b1;
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            qn_q  <= ~q_d;
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign q_o       = q_q;
    assign q_n_o     = qn_q;
    assign expired_o = exp_q;

`ifdef SR_FLAG_BANK_EDGE_OUT_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= ce_i & ~q_q & q_d;
            fall_q <= ce_i & q_q & ~q_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of N independent set/reset flags with selectable contention mode and timeout.
// Optional rise/fall pulse ports are enabled by defining SR_FLAG_BANK_EDGE_OUT_EN.
module sr_flag_bank
    import sr_flag_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned MODE    = MODE_RST_DOM,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ce,
    input  logic [N-1:0] set,
    input  logic [N-1:0] clr,
    output logic [N-1:0] q,
    output logic [N-1:0] q_n,
    output logic [N-1:0] expired
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
    ,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
`endif
);

    if ((N < 1) || (N > 32)) begin : g_bad_n
        $error("sr_flag_bank: N must be in 1..32");
    end
    if (MODE > MODE_HOLD) begin : g_bad_mode
        $error("sr_flag_bank: MODE must be 0..3");
    end
    if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("sr_flag_bank: TIMEOUT must be below 2**CNT_W");
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        sr_flag_cell #(
            .MODE   (MODE),
            .TIMEOUT(TIMEOUT),
            .CNT_W  (CNT_W)
        ) u_cell (
            .clk_i    (clock),
            .rst_i    (reset),
            .ce_i     (ce),
            .set_i    (set[i]),
            .clr_i    (clr[i]),
            .q_o      (q[i]),
            .q_n_o    (q_n[i]),
            .expired_o(expired[i])
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
            ,
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
`endif
        );
    end

endmodule

// File: tb/tb_sr_flag_bank.sv
// Scoreboard bench: four TIMEOUT=0 banks (one per MODE) sharing stimulus plus one TIMEOUT=3 bank.
module tb_sr_flag_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Contention-mode banks share these inputs
    logic       rst, ce;
    logic [3:0] s, c;
    logic [3:0] mq [4];
    logic [3:0] mqn [4];
    logic [3:0] mexp [4];
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
    logic [3:0] mrise [4];
    logic [3:0] mfall [4];
`endif

    // Timeout bank
    logic       trst, tce;
    logic [3:0] ts, tc;
    logic [3:0] tq, tqn, texp;
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
    logic [3:0] trise, tfall;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_m
        sr_flag_bank #(.N(4), .MODE(g), .TIMEOUT(0), .CNT_W(8)) u_dut (
            .clock  (clk),
            .reset  (rst),
            .ce     (ce),
            .set    (s),
            .clr    (c),
            .q      (mq[g]),
            .q_n    (mqn[g]),
            .expired(mexp[g])
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
            ,
            .rise   (mrise[g]),
            .fall   (mfall[g])
`endif
        );
    end

    sr_flag_bank #(.N(4), .MODE(0), .TIMEOUT(3), .CNT_W(8)) u_tdut (
        .clock  (clk),
        .reset  (trst),
        .ce     (tce),
        .set    (ts),
        .clr    (tc),
        .q      (tq),
        .q_n    (tqn),
        .expired(texp)
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
        ,
        .rise   (trise),
        .fall   (tfall)
`endif
    );

    typedef struct packed {
        logic [3:0][3:0] m;
        logic [3:0]      t;
        logic [3:0]      texp;
        logic [3:0]      r0, f0, tr, tf;
    } exp_t;

    exp_t sbq [$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0][3:0] e_m;
    logic [3:0]      e_t, e_texp;
    logic [3:0]      p_m0, p_t;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Push the expectation for the inputs currently driven, then advance one cycle.
    task automatic step();
        exp_t ex;
        ex.m    = e_m;
        ex.t    = e_t;
        ex.texp = e_texp;
        ex.r0   = (!rst && ce)   ? (e_m[0] & ~p_m0) : 4'b0000;
        ex.f0   = (!rst && ce)   ? (~e_m[0] & p_m0) : 4'b0000;
        ex.tr   = (!trst && tce) ? (e_t & ~p_t)     : 4'b0000;
        ex.tf   = (!trst && tce) ? (~e_t & p_t)     : 4'b0000;
        p_m0 = e_m[0];
        p_t  = e_t;
        sbq.push_back(ex);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (sbq.size() > 0) begin
            ex = sbq.pop_front();
            for (int unsigned i = 0; i < 4; i++) begin
                chk($sformatf("m%0d.q", i), mq[i], ex.m[i]);
                chk($sformatf("m%0d.q_n", i), mqn[i], ~ex.m[i]);
                chk($sformatf("m%0d.expired", i), mexp[i], 4'b0000);
            end
            chk("t.q", tq, ex.t);
            chk("t.q_n", tqn, ~ex.t);
            chk("t.expired", texp, ex.texp);
`ifdef SR_FLAG_BANK_EDGE_OUT_EN
            chk("m0.rise", mrise[0], ex.r0);
            chk("m0.fall", mfall[0], ex.f0);
            chk("t.rise", trise, ex.tr);
            chk("t.fall", tfall, ex.tf);
`endif
        end
    end

    initial begin
        rst = 1'b1; ce = 1'b1; s = '0; c = '0;
        trst = 1'b1; tce = 1'b1; ts = '0; tc = '0;
        e_m = '0; e_t = '0; e_texp = '0; p_m0 = '0; p_t = '0;
        @(negedge clk);

        // Reset, including reset overriding active set requests
        step();
        s = 4'b1111; ts = 4'b1111;
        step();
        rst = 1'b0; trst = 1'b0; s = '0; ts = '0;

        // Basic set, then hold for 10 cycles
        s = 4'b0101;
        for (int unsigned i = 0; i < 4; i++) e_m[i] = 4'b0101;
        step();
        s = '0;
        repeat (10) step();

        // Contention on channel 0 from q=1
        s = 4'b0001; c = 4'b0001;
        e_m[0] = 4'b0100; e_m[1] = 4'b0101; e_m[2] = 4'b0100; e_m[3] = 4'b0101;
        step();
        e_m[2] = 4'b0101;
        step();
        e_m[2] = 4'b0100;
        step();

        // Independent set/clear on different channels
        s = 4'b0010; c = 4'b0100;
        e_m[0] = 4'b0010; e_m[1] = 4'b0011; e_m[2] = 4'b0010; e_m[3] = 4'b0011;
        step();

        // Contention on channel 3 from q=0
        s = 4'b1000; c = 4'b1000;
        e_m[1] = 4'b1011; e_m[2] = 4'b1010;
        step();

        // Clock enable low freezes everything
        ce = 1'b0; s = 4'b1111; c = 4'b0000;
        step();
        s = 4'b0000; c = 4'b1111;
        step();
        ce = 1'b1; s = '0; c = 4'b1111;
        for (int unsigned i = 0; i < 4; i++) e_m[i] = 4'b0000;
        step();
        c = '0;

        // Single set pulse: high exactly 3 cycles, then expire
        ts = 4'b0100; e_t = 4'b0100;
        step();
        ts = '0;
        step(); step();
        e_t = 4'b0000; e_texp = 4'b0100;
        step();
        e_texp = 4'b0000;
        step();

        // Re-set while counter is 0: stays high another 3 cycles, no pulse
        ts = 4'b0100; e_t = 4'b0100;
        step();
        ts = '0;
        step(); step();
        ts = 4'b0100;
        step();
        ts = '0;
        step(); step();
        e_t = 4'b0000; e_texp = 4'b0100;
        step();
        e_texp = 4'b0000;
        step();

        // Clear mid-count: no expiry pulse
        ts = 4'b0100; e_t = 4'b0100;
        step();
        ts = '0;
        step();
        tc = 4'b0100; e_t = 4'b0000;
        step();
        tc = '0;
        step(); step(); step();

        // ce low for 5 cycles mid-count, then the count resumes
        ts = 4'b0100; e_t = 4'b0100;
        step();
        ts = '0;
        step();
        tce = 1'b0;
        repeat (5) step();
        tce = 1'b1;
        step();
        e_t = 4'b0000; e_texp = 4'b0100;
        step();
        e_texp = 4'b0000;
        step();

        // ce low exactly when counter hits 0 suppresses the expiry until re-enabled
        ts = 4'b0100; e_t = 4'b0100;
        step();
        ts = '0;
        step(); step();
        tce = 1'b0;
        step();
        tce = 1'b1; e_t = 4'b0000; e_texp = 4'b0100;
        step();
        e_texp = 4'b0000;
        step();

        // Reset mid-count: q drops with no expiry pulse, and no later expiry
        ts = 4'b0100; e_t = 4'b0100;
        step();
        ts = '0;
        step();
        trst = 1'b1; e_t = 4'b0000;
        step();
        trst = 1'b0;
        step(); step(); step();

        // Two channels armed one cycle apart expire independently
        ts = 4'b0001; e_t = 4'b0001;
        step();
        ts = 4'b1000; e_t = 4'b1001;
        step();
        ts = '0;
        step();
        e_t = 4'b1000; e_texp = 4'b0001;
        step();
        e_t = 4'b0000; e_texp = 4'b1000;
        step();
        e_texp = 4'b0000;
        step();

        repeat (3) @(negedge clk);
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
